// File: rtl/alu_pipe.sv
// alu_pipe: handshaked MIPS execute ALU with a registered result and pc-relative branch resolution.
// Define ALU_MULDIV_EN to add iterative mult/multu/div/divu; HI appears on result_hi.
module alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PC_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         src,
  input  logic [WIDTH-1:0]         targ,
  input  logic [WIDTH-1:0]         imm,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         jaddr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         result_hi,
  output logic                     br_taken,
  output logic                     illegal
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [WIDTH-1:0] IMM_LO_MASK = WIDTH'(17'h0_FFFF);

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] br_tgt;
  logic [SW-1:0]    var_amt;
  logic             alu_br;
  logic             alu_ill;
  logic             accept;
  logic             load_alu;
`ifdef ALU_MULDIV_EN
  logic             md_op;
  logic             md_load;
  logic [WIDTH-1:0] md_lo_res;
  logic [WIDTH-1:0] md_hi_res;
`endif

  assign var_amt = src[SW-1:0];
  assign br_tgt  = pc + (imm << PC_SHIFT);
  assign accept  = in_valid && in_ready;

  // Single-cycle decode/execute
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
`ifdef ALU_MULDIV_EN
    md_op   = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  alu_res = src + targ;
          F_SUB:  alu_res = src - targ;
          F_AND:  alu_res = src & targ;
          F_OR:   alu_res = src | targ;
          F_XOR:  alu_res = src ^ targ;
          F_NOR:  alu_res = ~(src | targ);
          F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src) < $signed(targ)};
          F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src < targ};
          F_SLL:  alu_res = targ << shamt;
          F_SRL:  alu_res = targ >> shamt;
          F_SRA:  alu_res = $unsigned($signed(targ) >>> shamt);
          F_SLLV: alu_res = targ << var_amt;
          F_SRLV: alu_res = targ >> var_amt;
          F_SRAV: alu_res = $unsigned($signed(targ) >>> var_amt);
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
`ifdef ALU_MULDIV_EN
            md_op = 1'b1;
`else
            alu_ill = 1'b1;
`endif
          end
          default: alu_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = src + imm;
      OP_ANDI: alu_res = src & (imm & IMM_LO_MASK);
      OP_ORI:  alu_res = src | (imm & IMM_LO_MASK);
      OP_SLTI: alu_res = {{(WIDTH-1){1'b0}}, $signed(src) < $signed(imm)};
      OP_BEQ: begin
        alu_br  = (src == targ);
        alu_res = alu_br ? br_tgt : pc;
      end
      OP_BNE: begin
        alu_br  = (src != targ);
        alu_res = alu_br ? br_tgt : pc;
      end
      OP_J: begin
        alu_br  = 1'b1;
        alu_res = jaddr;
      end
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, div0_q;
  logic             last_iter, md_start;
  logic             md_signed, src_neg, targ_neg;
  logic [WIDTH-1:0] src_mag, targ_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  assign last_iter = (cnt_q == SW'(WIDTH - 1));
  assign md_start  = accept && md_op;
  assign md_load   = (state_q == S_DONE);
  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign load_alu  = accept && !md_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_start) state_d = S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed ops iterate on magnitudes; the sign is restored when the result is loaded
  assign md_signed = (funct == F_MULT) || (funct == F_DIV);
  assign src_neg   = md_signed && src[WIDTH-1];
  assign targ_neg  = md_signed && targ[WIDTH-1];
  assign src_mag   = src_neg  ? -src  : src;
  assign targ_mag  = targ_neg ? -targ : targ;

  // One shift-add (mult) or restoring-subtract (div) bit per clock
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else if ((state_q == S_IDLE) && md_start) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      is_div_q <= funct[1];
      neg_lo_q <= src_neg ^ targ_neg;
      neg_hi_q <= src_neg;
      div0_q   <= (targ == '0);
      acc_lo_q <= funct[1] ? src_mag  : targ_mag;
      opb_q    <= funct[1] ? targ_mag : src_mag;
    end else if (state_q == S_BUSY) begin
      cnt_q    <= cnt_q + SW'(1);
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  // Sign fix-up; divide by zero yields all-ones quotient and remainder = src
  always_comb begin
    prod      = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    md_lo_res = prod[WIDTH-1:0];
    md_hi_res = prod[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      md_lo_res = div0_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
      md_hi_res = neg_hi_q ? -acc_hi_q : acc_hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        result_hi <= '0;
    else if (load_alu) result_hi <= '0;
    else if (md_load)  result_hi <= md_hi_res;
  end
`else
  assign in_ready  = !out_valid || out_ready;
  assign load_alu  = accept;
  assign result_hi = '0;
`endif

  // Output register: holds while stalled, drops valid after a transfer with no new load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      br_taken  <= alu_br;
      illegal   <= alu_ill;
`ifdef ALU_MULDIV_EN
    end else if (md_load) begin
      out_valid <= 1'b1;
      result    <= md_lo_res;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model.
// Follows ALU_MULDIV_EN the same way as the design.
module tb_alu_pipe;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src;
    logic [31:0] targ;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] jaddr;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        br;
    logic        ill;
  } exp_t;

  localparam logic [5:0] R_FUNCTS [18] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                           6'h18, 6'h19, 6'h1A, 6'h1B};
  localparam logic [5:0] I_OPS [9] = '{6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h02};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] src, targ, imm, pc, jaddr, result, result_hi;
  logic        br_taken, illegal;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t expq[$];
  logic        s_valid, s_ready, s_br, s_ill;
  logic [31:0] s_res, s_hi;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .PC_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .src(src), .targ(targ),
    .imm(imm), .pc(pc), .jaddr(jaddr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .br_taken(br_taken), .illegal(illegal)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t        e;
    longint      sa, st;
    logic [63:0] p;
    e  = '0;
    sa = longint'($signed(o.src));
    st = longint'($signed(o.targ));
    case (o.opcode)
      6'h00: begin
        case (o.funct)
          6'h20: e.res = o.src + o.targ;
          6'h22: e.res = o.src - o.targ;
          6'h24: e.res = o.src & o.targ;
          6'h25: e.res = o.src | o.targ;
          6'h26: e.res = o.src ^ o.targ;
          6'h27: e.res = ~(o.src | o.targ);
          6'h2A: e.res = (sa < st) ? 32'd1 : 32'd0;
          6'h2B: e.res = (o.src < o.targ) ? 32'd1 : 32'd0;
          6'h00: e.res = o.targ << o.shamt;
          6'h02: e.res = o.targ >> o.shamt;
          6'h03: e.res = 32'(st >>> o.shamt);
          6'h04: e.res = o.targ << o.src[4:0];
          6'h06: e.res = o.targ >> o.src[4:0];
          6'h07: e.res = 32'(st >>> o.src[4:0]);
`ifdef ALU_MULDIV_EN
          6'h18: begin p = 64'(sa * st); e.res = p[31:0]; e.hi = p[63:32]; end
          6'h19: begin p = {32'd0, o.src} * {32'd0, o.targ}; e.res = p[31:0]; e.hi = p[63:32]; end
          6'h1A: begin
            if (o.targ == 0) begin e.res = '1; e.hi = o.src; end
            else begin e.res = 32'(sa / st); e.hi = 32'(sa % st); end
          end
          6'h1B: begin
            if (o.targ == 0) begin e.res = '1; e.hi = o.src; end
            else begin e.res = o.src / o.targ; e.hi = o.src % o.targ; end
          end
`endif
          default: e.ill = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: e.res = o.src + o.imm;
      6'h0C: e.res = o.src & {16'd0, o.imm[15:0]};
      6'h0D: e.res = o.src | {16'd0, o.imm[15:0]};
      6'h0A: e.res = (sa < longint'($signed(o.imm))) ? 32'd1 : 32'd0;
      6'h04: begin e.br = (o.src == o.targ); e.res = e.br ? 32'(o.pc + o.imm * 4) : o.pc; end
      6'h05: begin e.br = (o.src != o.targ); e.res = e.br ? 32'(o.pc + o.imm * 4) : o.pc; end
      6'h02: begin e.br = 1'b1; e.res = o.jaddr; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t         o;
    logic [15:0] h;
    int          c;
    h       = 16'($urandom);
    o.src   = rand_val();
    o.targ  = rand_val();
    o.shamt = 5'($urandom);
    o.imm   = ($urandom_range(0, 1) == 1) ? {{16{h[15]}}, h} : rand_val();
    o.pc    = 32'($urandom) & 32'hFFFF_FFFC;
    o.jaddr = 32'($urandom);
    o.funct = 6'($urandom);
    c = $urandom_range(0, 9);
    if (c < 5) begin
      o.opcode = 6'h00;
      o.funct  = R_FUNCTS[$urandom_range(0, 17)];
      if (o.funct[5:1] == 5'b01101 && $urandom_range(0, 3) == 0) o.targ = 32'd0;
    end else if (c < 9) begin
      o.opcode = I_OPS[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 1) o.targ = o.src;
    end else begin
      o.opcode = 6'($urandom);
    end
    return o;
  endfunction

  // One clock: drive at negedge, sample outputs, score what transfers at the coming posedge
  task automatic cycle(input logic v, input op_t o, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = v; opcode = o.opcode; funct = o.funct; shamt = o.shamt;
    src = o.src; targ = o.targ; imm = o.imm; pc = o.pc; jaddr = o.jaddr;
    out_ready = ordy;
    #1;
    s_valid = out_valid; s_ready = in_ready; s_res = result; s_hi = result_hi;
    s_br = br_taken; s_ill = illegal;
    acc = v && in_ready;
    if (out_valid) begin
      check_eq("out_has_pending_op", 128'(expq.size() > 0), 128'(1));
      if (expq.size() > 0) begin
        check_eq("out_fields", {result, result_hi, br_taken, illegal}, expq[0]);
        if (ordy) void'(expq.pop_front());
      end
    end
    if (acc) expq.push_back(model(o));
  endtask

  task automatic run_op(input op_t o, input logic ordy, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      cycle(1'b1, o, ordy, acc);
      tries++;
    end
    check_eq("accept", 128'(acc), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    #1;
  endtask

  function automatic op_t mk(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] a,
                             input logic [31:0] b);
    op_t o;
    o = '0;
    o.opcode = opc; o.funct = fn; o.src = a; o.targ = b;
    return o;
  endfunction

  initial begin
    op_t  idle, o, cur;
    logic acc, pending;
    int   tries, lat;
    idle = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct = '0; shamt = '0; src = '0; targ = '0; imm = '0; pc = '0; jaddr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_outputs", {result, result_hi, br_taken, illegal}, 128'(0));

    run_op(mk(6'h00, 6'h20, 32'hFFFF_FFFF, 32'd1), 1'b1, tries);
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("add_wrap", {s_valid, s_res, s_ill}, {1'b1, 32'd0, 1'b0});

    // slt/sltu/sra back to back: each accepted first try, result one clock later
    run_op(mk(6'h00, 6'h2A, 32'hFFFF_FFFE, 32'd1), 1'b1, tries);
    run_op(mk(6'h00, 6'h2B, 32'hFFFF_FFFE, 32'd1), 1'b1, tries);
    check_eq("b2b_accept", 128'(tries), 128'(1));
    check_eq("slt_neg", s_res, 32'd1);
    o = mk(6'h00, 6'h03, 32'd0, 32'h8000_0000);
    o.shamt = 5'd4;
    run_op(o, 1'b1, tries);
    check_eq("sltu_big", s_res, 32'd0);
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("sra_arith", s_res, 32'hF800_0000);

    o = mk(6'h04, 6'h00, 32'd5, 32'd5);
    o.pc = 32'h100; o.imm = 32'hFFFF_FFFF;
    run_op(o, 1'b1, tries);
    o.opcode = 6'h05;
    run_op(o, 1'b1, tries);
    check_eq("beq_taken", {s_res, s_br}, {32'h0FC, 1'b1});
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("bne_not_taken", {s_res, s_br}, {32'h100, 1'b0});

    // Back-pressure: held result, new op waits until downstream frees the register
    run_op(mk(6'h00, 6'h20, 32'd1, 32'd2), 1'b0, tries);
    o = mk(6'h00, 6'h22, 32'd10, 32'd3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, o, 1'b0, acc);
      check_eq("stall_in_ready", {s_ready, s_valid, s_res}, {1'b0, 1'b1, 32'd3});
    end
    cycle(1'b1, o, 1'b1, acc);
    check_eq("release_accept", {acc, s_res}, {1'b1, 32'd3});
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("release_next", {s_valid, s_res}, {1'b1, 32'd7});
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("release_drained", {s_valid, 32'(expq.size())}, {1'b0, 32'd0});

    run_op(mk(6'h3F, 6'h00, 32'd9, 32'd9), 1'b1, tries);
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("illegal_op", {s_valid, s_res, s_ill, s_br}, {1'b1, 32'd0, 1'b1, 1'b0});

    // Reset while a result is held back drops it
    run_op(mk(6'h00, 6'h25, 32'hF0, 32'h0F), 1'b0, tries);
    cycle(1'b0, idle, 1'b0, acc);
    do_reset();
    check_eq("rst_drops_held", {out_valid, in_ready, result}, {1'b0, 1'b1, 32'd0});

`ifdef ALU_MULDIV_EN
    run_op(mk(6'h00, 6'h18, 32'hFFFF_FFFF, 32'd2), 1'b1, tries);
    lat = 0;
    cycle(1'b0, idle, 1'b1, acc);
    while (!s_valid && lat < 200) begin
      lat++;
      cycle(1'b0, idle, 1'b1, acc);
    end
    check_eq("mult_latency", 128'(lat), 128'(33));
    check_eq("mult_neg", {s_hi, s_res}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op(mk(6'h00, 6'h1B, 32'd7, 32'd0), 1'b1, tries);
    lat = 0;
    cycle(1'b0, idle, 1'b1, acc);
    while (!s_valid && lat < 200) begin
      lat++;
      cycle(1'b0, idle, 1'b1, acc);
    end
    check_eq("divu_by_zero", {s_res, s_hi}, {32'hFFFF_FFFF, 32'd7});

    // Reset mid-iteration aborts with no result
    run_op(mk(6'h00, 6'h1A, 32'd100, 32'd7), 1'b1, tries);
    repeat (5) cycle(1'b0, idle, 1'b1, acc);
    check_eq("busy_in_ready", 128'(s_ready), 128'(0));
    do_reset();
    check_eq("abort_state", {out_valid, in_ready}, {1'b0, 1'b1});
    repeat (40) cycle(1'b0, idle, 1'b1, acc);
    check_eq("abort_no_result", 128'(s_valid), 128'(0));
`else
    run_op(mk(6'h00, 6'h18, 32'd3, 32'd4), 1'b1, tries);
    cycle(1'b0, idle, 1'b1, acc);
    check_eq("mult_illegal", {s_valid, s_ill, s_res, s_hi}, {1'b1, 1'b1, 32'd0, 32'd0});
`endif

    // Randomized traffic with random gaps and back-pressure
    pending = 1'b0;
    cur = idle;
    for (int i = 0; i < 1500; i++) begin
      if (!pending && $urandom_range(0, 9) < 8) begin
        cur = rand_op();
        pending = 1'b1;
      end
      cycle(pending, cur, $urandom_range(0, 9) < 7, acc);
      if (acc) pending = 1'b0;
    end
    for (int i = 0; i < 200 && expq.size() > 0; i++) cycle(1'b0, idle, 1'b1, acc);
    check_eq("drain_empty", 128'(expq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
